// File: rtl/fp16_align_stage_if.sv
// fp16_align_stage_if
//   Handshake and data bundle for the FP16 pre-add alignment stage.
//   Input side : inValid/inReady with operands opA/opB.
//   Output side: outValid/outReady with the aligned pair and special flags.
//   modport slave  : the alignment stage itself.
//   modport master : the upstream/downstream environment driving it.
interface fp16_align_stage_if #(
  parameter int SIG_W = 14,
  parameter int EXP_W = 5
);
  logic             inValid;
  logic             inReady;
  logic [15:0]      opA;
  logic [15:0]      opB;
  logic             outValid;
  logic             outReady;
  logic             signBig;
  logic             effSub;
  logic [EXP_W-1:0] expBig;
  logic [SIG_W-1:0] sigBig;
  logic [SIG_W-1:0] sigSmall;
  logic             swapped;
  logic             isNaN;
  logic             isInf;

  modport slave (
    input  inValid, opA, opB, outReady,
    output inReady, outValid, signBig, effSub, expBig, sigBig, sigSmall,
           swapped, isNaN, isInf
  );

  modport master (
    output inValid, opA, opB, outReady,
    input  inReady, outValid, signBig, effSub, expBig, sigBig, sigSmall,
           swapped, isNaN, isInf
  );
endinterface

// File: rtl/fp16_align_stage.sv
// fp16_align_stage
//   Front end of the FP16 adder. Orders two operands by magnitude, computes
//   the exponent difference with a KPG prefix adder (big + ~small, carry-in
//   generate), then right-shifts the smaller significand with guard/round/
//   sticky. Two pipeline stages with valid/ready flow control.
//   Ports:
//     clk  - rising-edge clock
//     rstN - asynchronous active-low reset
//     bus  - fp16_align_stage_if.slave (operands in, aligned pair out)

// Per-operand field decode. One instance per operand.
module fp16_align_dec (
  input  logic [15:0] op,
  output logic        sign,
  output logic [4:0]  exp_eff,
  output logic [10:0] sig,
  output logic [14:0] mag,
  output logic        nan,
  output logic        inf
);
  logic hidden;
  logic exp_max;
  logic frac_nz;

  assign hidden  = |op[14:10];
  assign exp_max = &op[14:10];
  assign frac_nz = |op[9:0];

  assign sign    = op[15];
  // Subnormals share the exponent of the smallest normal.
  assign exp_eff = hidden ? op[14:10] : 5'd1;
  assign sig     = {hidden, op[9:0]};
  assign mag     = op[14:0];
  assign nan     = exp_max & frac_nz;
  assign inf     = exp_max & ~frac_nz;
endmodule

module fp16_align_stage #(
  parameter int SIG_W = 14,
  parameter int EXP_W = 5
) (
  input logic               clk,
  input logic               rstN,
  fp16_align_stage_if.slave bus
);
  localparam int STAGES = 2;
  localparam int MAN_W  = SIG_W - 3;            // hidden + fraction
  localparam int LVLS   = $clog2(EXP_W + 1);    // prefix tree depth
  localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(SIG_W);

  typedef struct packed {
    logic             sign_big;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_big;
    logic [SIG_W-1:0] sig_big;
    logic [MAN_W-1:0] sig_small;
    logic [EXP_W-1:0] diff;
    logic             swapped;
    logic             nan;
    logic             inf;
  } s1_t;

  typedef struct packed {
    logic             sign_big;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_big;
    logic [SIG_W-1:0] sig_big;
    logic [SIG_W-1:0] sig_small;
    logic             swapped;
    logic             nan;
    logic             inf;
  } s2_t;

  // Kogge-Stone style KPG prefix add of a + b with carry-in forced to
  // generate. Position 0 of the extended vectors models the carry-in.
  function automatic logic [EXP_W-1:0] kpg_add_cin1(
    input logic [EXP_W-1:0] a,
    input logic [EXP_W-1:0] b
  );
    logic [EXP_W:0]   g;
    logic [EXP_W:0]   p;
    logic [EXP_W-1:0] x;
    x = a ^ b;
    g = {a & b, 1'b1};
    p = {x, 1'b0};
    for (int l = 0; l < LVLS; l++) begin
      // Descending index so g[i-d]/p[i-d] still hold the previous level.
      for (int i = EXP_W; i >= (1 << l); i--) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    // g[i] is now the carry into data bit i.
    return x ^ g[EXP_W-1:0];
  endfunction

  // Right shift with every shifted-out bit folded into the sticky LSB.
  function automatic logic [SIG_W-1:0] align_shift(
    input logic [MAN_W-1:0] man,
    input logic [EXP_W-1:0] diff
  );
    logic [SIG_W-1:0] full;
    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] lost_mask;
    full = {man, 3'b000};
    if (diff >= SHIFT_SAT) begin
      shifted = {{(SIG_W-1){1'b0}}, |man};
    end else begin
      shifted    = full >> diff;
      lost_mask  = ~({SIG_W{1'b1}} << diff);
      shifted[0] = shifted[0] | (|(full & lost_mask));
    end
    return shifted;
  endfunction

  // ---------------- operand decode ----------------
  logic [1:0]            sign;
  logic [1:0][EXP_W-1:0] exp_eff;
  logic [1:0][MAN_W-1:0] man;
  logic [1:0][14:0]      mag;
  logic [1:0]            nan;
  logic [1:0]            inf;
  logic [1:0][15:0]      ops;

  assign ops = {bus.opB, bus.opA};

  for (genvar k = 0; k < 2; k++) begin : g_dec
    fp16_align_dec u_dec (
      .op      (ops[k]),
      .sign    (sign[k]),
      .exp_eff (exp_eff[k]),
      .sig     (man[k]),
      .mag     (mag[k]),
      .nan     (nan[k]),
      .inf     (inf[k])
    );
  end

  // ---------------- flow control ----------------
  logic [STAGES:1] vld_pipe;
  logic            s1_adv;
  logic            in_rdy;
  logic            in_fire;
  logic            s1_fire;

  assign s1_adv  = !vld_pipe[2] || bus.outReady;
  assign in_rdy  = !vld_pipe[1] || s1_adv;
  assign in_fire = bus.inValid && in_rdy;
  assign s1_fire = vld_pipe[1] && s1_adv;

  // ---------------- stage 1 compute ----------------
  s1_t s1, s1_nxt;
  s2_t s2, s2_nxt;
  logic swap;
  logic nan_any;

  // Equal magnitudes keep A as the big operand.
  assign swap = mag[1] > mag[0];

  always_comb begin
    s1_nxt           = '0;
    s1_nxt.swapped   = swap;
    s1_nxt.sign_big  = swap ? sign[1] : sign[0];
    s1_nxt.eff_sub   = sign[0] ^ sign[1];
    s1_nxt.exp_big   = swap ? exp_eff[1] : exp_eff[0];
    s1_nxt.sig_big   = {(swap ? man[1] : man[0]), 3'b000};
    s1_nxt.sig_small = swap ? man[0] : man[1];
    s1_nxt.diff      = kpg_add_cin1(swap ? exp_eff[1] : exp_eff[0],
                                    ~(swap ? exp_eff[0] : exp_eff[1]));
    // inf - inf has no defined result.
    nan_any          = (|nan) || (&inf && s1_nxt.eff_sub);
    s1_nxt.nan       = nan_any;
    s1_nxt.inf       = !nan_any && (|inf);
  end

  // ---------------- stage 2 compute ----------------
  always_comb begin
    s2_nxt           = '0;
    s2_nxt.sign_big  = s1.sign_big;
    s2_nxt.eff_sub   = s1.eff_sub;
    s2_nxt.exp_big   = s1.exp_big;
    s2_nxt.sig_big   = s1.sig_big;
    s2_nxt.sig_small = align_shift(s1.sig_small, s1.diff);
    s2_nxt.swapped   = s1.swapped;
    s2_nxt.nan       = s1.nan;
    s2_nxt.inf       = s1.inf;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (in_rdy)  vld_pipe[1] <= bus.inValid;
      if (s1_adv)  vld_pipe[2] <= vld_pipe[1];
      if (in_fire) s1 <= s1_nxt;
      if (s1_fire) s2 <= s2_nxt;
    end
  end

  // ---------------- outputs ----------------
  assign bus.inReady  = in_rdy;
  assign bus.outValid = vld_pipe[2];
  assign bus.signBig  = s2.sign_big;
  assign bus.effSub   = s2.eff_sub;
  assign bus.expBig   = s2.exp_big;
  assign bus.sigBig   = s2.sig_big;
  assign bus.sigSmall = s2.sig_small;
  assign bus.swapped  = s2.swapped;
  assign bus.isNaN    = s2.nan;
  assign bus.isInf    = s2.inf;
endmodule

// File: tb/tb_fp16_align_stage.sv
// tb_fp16_align_stage
//   Directed vectors with hand-computed aligned outputs, checked through a
//   scoreboard on every output transfer, plus latency, throughput,
//   back-pressure and asynchronous-reset scenarios.
module tb_fp16_align_stage;
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  fp16_align_stage_if #(.SIG_W(14), .EXP_W(5)) bus ();

  fp16_align_stage #(.SIG_W(14), .EXP_W(5)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [37:0] sb[$];
  string       tq[$];

  logic [15:0] va [13];
  logic [15:0] vb [13];
  logic [37:0] ve [13];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [37:0] mk(input logic sbig, input logic esub,
                                     input logic [4:0] e, input logic [13:0] bg,
                                     input logic [13:0] sm, input logic sw,
                                     input logic nn, input logic inf);
    return {sbig, esub, e, bg, sm, sw, nn, inf};
  endfunction

  function automatic logic [37:0] obs_out();
    return {bus.signBig, bus.effSub, bus.expBig, bus.sigBig, bus.sigSmall,
            bus.swapped, bus.isNaN, bus.isInf};
  endfunction

  // Output monitor: every transfer must match the oldest outstanding pair.
  always @(negedge clk) begin
    if (rstN && bus.outValid && bus.outReady) begin
      if (sb.size() == 0) begin
        chk("extra_out", 64'(bus.outValid), 64'd0);
      end else begin
        chk({"out_", tq[0]}, 64'(obs_out()), 64'(sb[0]));
        void'(sb.pop_front());
        void'(tq.pop_front());
      end
    end
  end

  // Present a pair and hold it until accepted; call just after a posedge.
  task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [37:0] e);
    bus.opA     = a;
    bus.opB     = b;
    bus.inValid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.inReady) break;
    end
    if (!bus.inReady) chk({"send_tmo_", tag}, 64'(bus.inReady), 64'd1);
    @(posedge clk);
    sb.push_back(e);
    tq.push_back(tag);
    #1;
    bus.inValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    time t0, t1;

    va[0]  = 16'h3C00; vb[0]  = 16'h3C00; ve[0]  = mk(0, 0, 15, 14'h2000, 14'h2000, 0, 0, 0);
    va[1]  = 16'h3800; vb[1]  = 16'h3C00; ve[1]  = mk(0, 0, 15, 14'h2000, 14'h1000, 1, 0, 0);
    va[2]  = 16'h3C00; vb[2]  = 16'h8001; ve[2]  = mk(0, 1, 15, 14'h2000, 14'h0001, 0, 0, 0);
    va[3]  = 16'h7C00; vb[3]  = 16'hFC00; ve[3]  = mk(0, 1, 31, 14'h2000, 14'h2000, 0, 1, 0);
    va[4]  = 16'h7C00; vb[4]  = 16'h3C00; ve[4]  = mk(0, 0, 31, 14'h2000, 14'h0001, 0, 0, 1);
    va[5]  = 16'h7E00; vb[5]  = 16'h3C00; ve[5]  = mk(0, 0, 31, 14'h3000, 14'h0001, 0, 1, 0);
    va[6]  = 16'h3C00; vb[6]  = 16'h3401; ve[6]  = mk(0, 0, 15, 14'h2000, 14'h0802, 0, 0, 0);
    va[7]  = 16'h3C00; vb[7]  = 16'h2C01; ve[7]  = mk(0, 0, 15, 14'h2000, 14'h0201, 0, 0, 0);
    va[8]  = 16'h0003; vb[8]  = 16'h0001; ve[8]  = mk(0, 0,  1, 14'h0018, 14'h0008, 0, 0, 0);
    va[9]  = 16'h3C00; vb[9]  = 16'h0801; ve[9]  = mk(0, 0, 15, 14'h2000, 14'h0001, 0, 0, 0);
    va[10] = 16'hC000; vb[10] = 16'h3C00; ve[10] = mk(1, 1, 16, 14'h2000, 14'h1000, 0, 0, 0);
    va[11] = 16'h0000; vb[11] = 16'h8000; ve[11] = mk(0, 1,  1, 14'h0000, 14'h0000, 0, 0, 0);
    va[12] = 16'h3C00; vb[12] = 16'h7C01; ve[12] = mk(0, 0, 31, 14'h2008, 14'h0001, 1, 1, 0);

    bus.inValid  = 1'b0;
    bus.opA      = '0;
    bus.opB      = '0;
    bus.outReady = 1'b1;
    rstN         = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outvalid", 64'(bus.outValid), 64'd0);
    chk("rst_data", 64'(obs_out()), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_inready", 64'(bus.inReady), 64'd1);
    @(posedge clk);
    #1;

    // Two-cycle latency on 1.0 + 1.0
    send("v0", va[0], vb[0], ve[0]);
    @(negedge clk);
    chk("lat_cycle1", 64'(bus.outValid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2", 64'(bus.outValid), 64'd1);
    drain("drain_v0");
    @(posedge clk);
    #1;

    // Back-to-back stream, one pair per cycle
    t0 = $time;
    for (int i = 1; i < 13; i++) send($sformatf("v%0d", i), va[i], vb[i], ve[i]);
    t1 = $time;
    chk("stream_cycles", 64'((t1 - t0) / 10), 64'd12);
    drain("drain_stream");
    @(posedge clk);
    #1;

    // Back-pressure: two pairs fill the pipe, then input stalls
    bus.outReady = 1'b0;
    send("bp0", va[1], vb[1], ve[1]);
    send("bp1", va[6], vb[6], ve[6]);
    bus.opA     = va[7];
    bus.opB     = vb[7];
    bus.inValid = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk($sformatf("bp_inready_%0d", h), 64'(bus.inReady), 64'd0);
      chk($sformatf("bp_outvalid_%0d", h), 64'(bus.outValid), 64'd1);
      chk($sformatf("bp_hold_%0d", h), 64'(obs_out()), 64'(ve[1]));
    end
    @(posedge clk);
    #1;
    bus.outReady = 1'b1;
    send("bp2", va[7], vb[7], ve[7]);
    send("bp3", va[8], vb[8], ve[8]);
    drain("drain_bp");
    @(posedge clk);
    #1;

    // Asynchronous reset with two pairs in flight
    send("r0", va[0], vb[0], ve[0]);
    send("r1", va[2], vb[2], ve[2]);
    #1;
    rstN = 1'b0;
    #1;
    chk("async_rst_outvalid", 64'(bus.outValid), 64'd0);
    sb.delete();
    tq.delete();
    @(negedge clk);
    chk("rst_held_outvalid", 64'(bus.outValid), 64'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    send("post_rst", va[10], vb[10], ve[10]);
    @(negedge clk);
    chk("post_rst_lat1", 64'(bus.outValid), 64'd0);
    @(negedge clk);
    chk("post_rst_lat2", 64'(bus.outValid), 64'd1);
    drain("drain_post_rst");
    repeat (3) @(negedge clk);
    chk("idle_outvalid", 64'(bus.outValid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
